// File: rtl/traffic_phase_ctrl.sv
// Two-road intersection phase sequencer.
// Steps MAIN_G -> MAIN_Y -> RED_1 -> SIDE_G -> SIDE_Y -> RED_2 on a 1 Hz tick.
// Each phase has its own down-counter. Main green holds at its final second
// until a side-road request is pending. en=0 parks the block in all-red.
module traffic_phase_ctrl #(
   parameter int pGREEN_MAIN = 30,
   parameter int pGREEN_SIDE = 20,
   parameter int pYELLOW     = 3,
   parameter int pALL_RED    = 2,
   // Width needed for (longest duration - 1), never below 1 bit.
   parameter int pCNT_W = $clog2(
      ((((pGREEN_MAIN > pGREEN_SIDE) ? pGREEN_MAIN : pGREEN_SIDE) >
        ((pYELLOW > pALL_RED) ? pYELLOW : pALL_RED))
         ? ((pGREEN_MAIN > pGREEN_SIDE) ? pGREEN_MAIN : pGREEN_SIDE)
         : ((pYELLOW > pALL_RED) ? pYELLOW : pALL_RED)) > 2
      ? ((((pGREEN_MAIN > pGREEN_SIDE) ? pGREEN_MAIN : pGREEN_SIDE) >
          ((pYELLOW > pALL_RED) ? pYELLOW : pALL_RED))
         ? ((pGREEN_MAIN > pGREEN_SIDE) ? pGREEN_MAIN : pGREEN_SIDE)
         : ((pYELLOW > pALL_RED) ? pYELLOW : pALL_RED))
      : 2)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tick,
   input  logic              en,
   input  logic              side_req,
   output logic [2:0]        main_light,
   output logic [2:0]        side_light,
   output logic [2:0]        phase,
   output logic [pCNT_W-1:0] remaining,
   output logic              req_pend
);

   typedef enum logic [2:0] {
      MAIN_G = 3'd0,
      MAIN_Y = 3'd1,
      RED_1  = 3'd2,
      SIDE_G = 3'd3,
      SIDE_Y = 3'd4,
      RED_2  = 3'd5
   } state_t;

   localparam logic [2:0] LAMP_R = 3'b100;
   localparam logic [2:0] LAMP_Y = 3'b010;
   localparam logic [2:0] LAMP_G = 3'b001;

   state_t            state_q, state_d;
   logic [pCNT_W-1:0] rem_q, rem_d;
   logic [2:0]        main_d, side_d;
   logic              pend_d;

   // Value loaded into the counter on entry to a phase (duration - 1).
   function automatic logic [pCNT_W-1:0] load(input state_t s);
      case (s)
         MAIN_G:         load = pCNT_W'(pGREEN_MAIN - 1);
         MAIN_Y, SIDE_Y: load = pCNT_W'(pYELLOW - 1);
         SIDE_G:         load = pCNT_W'(pGREEN_SIDE - 1);
         default:        load = pCNT_W'(pALL_RED - 1);
      endcase
   endfunction

   function automatic state_t succ(input state_t s);
      case (s)
         MAIN_G:  succ = MAIN_Y;
         MAIN_Y:  succ = RED_1;
         RED_1:   succ = SIDE_G;
         SIDE_G:  succ = SIDE_Y;
         SIDE_Y:  succ = RED_2;
         default: succ = MAIN_G;
      endcase
   endfunction

   // Next state, counter, request latch and lamp decode.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      if (!en) begin
         state_d = RED_2;
         rem_d   = load(RED_2);
      end else begin
         case (state_q)
            MAIN_G, MAIN_Y, RED_1, SIDE_G, SIDE_Y, RED_2: begin
               if (tick) begin
                  if (rem_q != '0) begin
                     rem_d = rem_q - pCNT_W'(1);
                  end else if (state_q != MAIN_G || req_pend || side_req) begin
                     state_d = succ(state_q);
                     rem_d   = load(state_d);
                  end
               end
            end
            default: begin
               // Codes 6/7 are unreachable in normal operation; park in all-red.
               state_d = RED_2;
               rem_d   = load(RED_2);
            end
         endcase
      end

      // Entering side green consumes the request, even one arriving that cycle.
      if (state_d == SIDE_G && state_q != SIDE_G) pend_d = 1'b0;
      else                                        pend_d = req_pend | side_req;

      // Lamps are decoded from the next state so they change on the same edge.
      main_d = LAMP_R;
      side_d = LAMP_R;
      case (state_d)
         MAIN_G:  main_d = LAMP_G;
         MAIN_Y:  main_d = LAMP_Y;
         SIDE_G:  side_d = LAMP_G;
         SIDE_Y:  side_d = LAMP_Y;
         default: ;
      endcase
   end

   // State register; reset lands in the safe all-red clearance phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RED_2;
         rem_q      <= load(RED_2);
         main_light <= LAMP_R;
         side_light <= LAMP_R;
         req_pend   <= 1'b0;
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
         main_light <= main_d;
         side_light <= side_d;
         req_pend   <= pend_d;
      end
   end

   assign phase     = state_q;
   assign remaining = rem_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: a phase-index / elapsed-seconds model is
// compared against the DUT every cycle, and directed literal checks anchor it.
module tb_traffic_phase_ctrl;

   localparam int GM = 4;
   localparam int GS = 3;
   localparam int YL = 2;
   localparam int AR = 1;
   localparam int W  = 2;

   logic         clk = 1'b0;
   logic         rst_n, tick, en, side_req;
   logic [2:0]   main_light, side_light, phase;
   logic [W-1:0] remaining;
   logic         req_pend;

   int checks   = 0;
   int failures = 0;

   int eph [14] = '{0, 0, 0, 0, 1, 1, 2, 3, 3, 3, 4, 4, 5, 0};
   int erm [14] = '{3, 2, 1, 0, 1, 0, 0, 2, 1, 0, 1, 0, 0, 3};

   traffic_phase_ctrl #(
      .pGREEN_MAIN(GM), .pGREEN_SIDE(GS), .pYELLOW(YL), .pALL_RED(AR)
   ) dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .en(en), .side_req(side_req),
      .main_light(main_light), .side_light(side_light), .phase(phase),
      .remaining(remaining), .req_pend(req_pend)
   );

   always #5 clk = ~clk;

   // Model: phase index 0..5 plus seconds elapsed in that phase.
   typedef struct packed {
      logic [2:0] ph;
      logic [7:0] el;
      logic       pend;
   } mstate_t;

   mstate_t m;

   function automatic int dur(input int ph);
      case (ph)
         0:       dur = GM;
         1:       dur = YL;
         2:       dur = AR;
         3:       dur = GS;
         4:       dur = YL;
         default: dur = AR;
      endcase
   endfunction

   function automatic mstate_t step(input mstate_t s, input logic e,
                                    input logic t, input logic r);
      mstate_t n;
      n = s;
      if (!e) begin
         n.ph = 3'd5;
         n.el = 8'd0;
      end else if (t) begin
         if (int'(s.el) + 1 < dur(int'(s.ph))) n.el = s.el + 8'd1;
         else if (s.ph == 3'd0 && !(s.pend || r)) n.el = s.el;
         else begin
            n.ph = (s.ph == 3'd5) ? 3'd0 : s.ph + 3'd1;
            n.el = 8'd0;
         end
      end
      n.pend = (n.ph == 3'd3 && s.ph != 3'd3) ? 1'b0 : (r ? 1'b1 : s.pend);
      return n;
   endfunction

   function automatic int lamp_main(input int ph);
      lamp_main = (ph == 0) ? 1 : (ph == 1) ? 2 : 4;
   endfunction

   function automatic int lamp_side(input int ph);
      lamp_side = (ph == 3) ? 1 : (ph == 4) ? 2 : 4;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= '{ph: 3'd5, el: 8'd0, pend: 1'b0};
      else        m <= step(m, en, tick, side_req);
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, sampled on the falling edge.
   always @(negedge clk) begin
      chk("m_phase", int'(phase), int'(m.ph));
      chk("m_remaining", int'(remaining), dur(int'(m.ph)) - 1 - int'(m.el));
      chk("m_main_light", int'(main_light), lamp_main(int'(m.ph)));
      chk("m_side_light", int'(side_light), lamp_side(int'(m.ph)));
      chk("m_req_pend", int'(req_pend), int'(m.pend));
      chk("both_non_red", int'(main_light != 3'b100 && side_light != 3'b100), 0);
   end

   task automatic step1();
      @(posedge clk);
      #1;
   endtask

   // Four idle clocks then one tick clock: one tick every 5 clocks.
   task automatic tick_once();
      repeat (4) step1();
      tick = 1'b1;
      step1();
      tick = 1'b0;
   endtask

   task automatic run_ticks(input int n);
      for (int i = 0; i < n; i++) tick_once();
   endtask

   task automatic chk_ph(input string nm, input int ph, input int rm);
      chk({nm, "_phase"}, int'(phase), ph);
      chk({nm, "_rem"}, int'(remaining), rm);
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b1; side_req = 1'b1; tick = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_ph("reset", 5, 0);
      chk("reset_main", int'(main_light), 4);
      chk("reset_side", int'(side_light), 4);
      chk("reset_pend", int'(req_pend), 0);
      rst_n = 1'b1;
      step1();
      chk("pend_set", int'(req_pend), 1);

      // Full cycle with the request held: dwell 4,2,1,3,2,1.
      for (int i = 0; i < 14; i++) begin
         tick_once();
         chk_ph("seq", eph[i], erm[i]);
      end

      // Drain the request through SIDE_G, come back to main green.
      side_req = 1'b0;
      run_ticks(13);
      chk_ph("back_main", 0, 3);
      chk("back_pend", int'(req_pend), 0);
      run_ticks(3);
      for (int i = 0; i < 10; i++) begin
         tick_once();
         chk_ph("hold", 0, 0);
      end
      step1();
      side_req = 1'b1;
      step1();
      side_req = 1'b0;
      chk("pulse_pend", int'(req_pend), 1);
      tick_once();
      chk_ph("to_yellow", 1, 1);

      // Request coincident with the edge entering SIDE_G is consumed.
      run_ticks(2);
      chk_ph("red1", 2, 0);
      repeat (4) step1();
      tick = 1'b1; side_req = 1'b1;
      step1();
      tick = 1'b0; side_req = 1'b0;
      chk_ph("enter_sg", 3, 2);
      chk("enter_sg_pend", int'(req_pend), 0);
      side_req = 1'b1;
      step1();
      side_req = 1'b0;
      chk("late_pend", int'(req_pend), 1);

      // en drop in SIDE_G with remaining=1.
      tick_once();
      chk_ph("sg_rem1", 3, 1);
      en = 1'b0;
      step1();
      chk_ph("en_low", 5, 0);
      chk("en_low_main", int'(main_light), 4);
      chk("en_low_side", int'(side_light), 4);
      run_ticks(3);
      chk_ph("en_low_ticks", 5, 0);
      en = 1'b1;
      step1();
      chk_ph("en_back", 5, 0);
      tick_once();
      chk_ph("en_main", 0, 3);

      // Asynchronous reset in the middle of MAIN_Y.
      run_ticks(4);
      chk_ph("main_y", 1, 1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk_ph("async_rst", 5, 0);
      chk("async_rst_main", int'(main_light), 4);
      chk("async_rst_side", int'(side_light), 4);
      chk("async_rst_pend", int'(req_pend), 0);
      step1();
      rst_n = 1'b1;
      step1();
      tick_once();
      chk_ph("post_rst", 0, 3);

      // tick with en=0 at RED_1 remaining=0: en wins.
      step1();
      side_req = 1'b1;
      step1();
      side_req = 1'b0;
      run_ticks(6);
      chk_ph("red1_again", 2, 0);
      repeat (4) step1();
      tick = 1'b1; en = 1'b0;
      step1();
      tick = 1'b0; en = 1'b1;
      chk_ph("tick_en_low", 5, 0);
      tick_once();
      chk_ph("after_tick_en", 0, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
